multicycle_control: RTL and testbench

Main control state machine for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and write-back. Fetch and memory cycles stall on a memory-ready handshake. It generates every datapath enable and mux select, plus the `alu_op`/`i_op` pair consumed directly by the ALU operation decoder downstream.

---
 rtl/multicycle_control.sv | 164 ++++++++++++++++
 tb/tb_multicycle_control.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/write-back and drives every datapath enable and select.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic [2:0] i_op,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_RESET     = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_MEM_ADDR  = 4'd3;
  localparam logic [3:0] S_MEM_READ  = 4'd4;
  localparam logic [3:0] S_MEM_WB    = 4'd5;
  localparam logic [3:0] S_MEM_WRITE = 4'd6;
  localparam logic [3:0] S_R_EXEC    = 4'd7;
  localparam logic [3:0] S_R_WB      = 4'd8;
  localparam logic [3:0] S_BRANCH    = 4'd9;
  localparam logic [3:0] S_JUMP      = 4'd10;
  localparam logic [3:0] S_I_EXEC    = 4'd11;
  localparam logic [3:0] S_I_WB      = 4'd12;

  logic [3:0] state_q, state_d;
  logic [2:0] i_op_q, i_op_d;
  logic       is_bne_q, is_bne_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RESET;
      i_op_q   <= 3'b000;
      is_bne_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_op_q   <= i_op_d;
      is_bne_q <= is_bne_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    i_op_d     = i_op_q;
    is_bne_d   = is_bne_q;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ext_zero   = 1'b0;
    pc_source  = 2'b00;
    alu_op     = 2'b00;
    illegal    = 1'b0;

    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR and PC load only in the cycle the instruction word arrives
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) state_d = S_FETCH + 4'd1;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        i_op_d    = opcode[2:0];
        is_bne_d  = (opcode == 6'b000101);
        casez (opcode)
          6'b000000:             state_d = S_R_EXEC;
          6'b100011, 6'b101011:  state_d = S_MEM_ADDR;
          6'b000100, 6'b000101:  state_d = S_BRANCH;
          6'b000010:             state_d = S_JUMP;
          6'b001???:             state_d = S_I_EXEC;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == 6'b101011) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_source = 2'b01;
        // bne inverts the sense of the ALU zero flag
        pc_en     = zero ^ is_bne_q;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_en     = 1'b1;
        state_d   = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        // andi/ori/xori take a zero-extended immediate
        ext_zero  = (i_op_q == 3'b100) || (i_op_q == 3'b101) || (i_op_q == 3'b110);
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_RESET;
    endcase
  end

  assign i_op  = i_op_q;
  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by cycle
// and compares state plus the packed control word against hand-written values.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, ext_zero, illegal;
  logic [1:0] alu_src_b, pc_source, alu_op;
  logic [2:0] i_op;
  logic [3:0] state;
  logic [16:0] ctl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_zero(ext_zero), .pc_source(pc_source), .alu_op(alu_op), .i_op(i_op),
    .illegal(illegal), .state(state)
  );

  // Packed order: pc_en iord mem_read mem_write ir_write reg_dst mem_to_reg reg_write
  //               alu_src_a alu_src_b[2] ext_zero pc_source[2] alu_op[2] illegal
  assign ctl = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                alu_src_a, alu_src_b, ext_zero, pc_source, alu_op, illegal};

  localparam logic [16:0] C_ZERO  = 17'b0_0_0_0_0_0_0_0_0_00_0_00_00_0;
  localparam logic [16:0] C_FW    = 17'b0_0_1_0_0_0_0_0_0_01_0_00_00_0;
  localparam logic [16:0] C_FR    = 17'b1_0_1_0_1_0_0_0_0_01_0_00_00_0;
  localparam logic [16:0] C_DEC   = 17'b0_0_0_0_0_0_0_0_0_11_0_00_00_0;
  localparam logic [16:0] C_ILL   = 17'b0_0_0_0_0_0_0_0_0_11_0_00_00_1;
  localparam logic [16:0] C_REX   = 17'b0_0_0_0_0_0_0_0_1_00_0_00_10_0;
  localparam logic [16:0] C_RWB   = 17'b0_0_0_0_0_1_0_1_0_00_0_00_00_0;
  localparam logic [16:0] C_MADDR = 17'b0_0_0_0_0_0_0_0_1_10_0_00_00_0;
  localparam logic [16:0] C_MRD   = 17'b0_1_1_0_0_0_0_0_0_00_0_00_00_0;
  localparam logic [16:0] C_MWB   = 17'b0_0_0_0_0_0_1_1_0_00_0_00_00_0;
  localparam logic [16:0] C_MWR   = 17'b0_1_0_1_0_0_0_0_0_00_0_00_00_0;
  localparam logic [16:0] C_BR0   = 17'b0_0_0_0_0_0_0_0_1_00_0_01_01_0;
  localparam logic [16:0] C_BR1   = 17'b1_0_0_0_0_0_0_0_1_00_0_01_01_0;
  localparam logic [16:0] C_JMP   = 17'b1_0_0_0_0_0_0_0_0_00_0_10_00_0;
  localparam logic [16:0] C_IEX0  = 17'b0_0_0_0_0_0_0_0_1_10_0_00_11_0;
  localparam logic [16:0] C_IEX1  = 17'b0_0_0_0_0_0_0_0_1_10_1_00_11_0;
  localparam logic [16:0] C_IWB   = 17'b0_0_0_0_0_0_0_1_0_00_0_00_00_0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] es [5];
    es = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd1};
    rst_n = 1'b0; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b0;
    repeat (3) tick();
    total++; if (state !== 4'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
    total++; if (ctl !== C_ZERO) begin bad++; $display("FAIL rst_ctl got=%b exp=%b", ctl, C_ZERO); end
    total++; if (i_op !== 3'b000) begin bad++; $display("FAIL rst_iop got=%b exp=000", i_op); end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (state !== es[i]) begin bad++; $display("FAIL stall_state[%0d] got=%0d exp=%0d", i, state, es[i]); end
      if (i > 0) begin
        total++;
        if (ctl !== C_FW) begin bad++; $display("FAIL stall_ctl[%0d] got=%b exp=%b", i, ctl, C_FW); end
      end
      tick();
    end
    mem_ready = 1'b1; #1;
    total++; if (ctl !== C_FR) begin bad++; $display("FAIL fetch_ready_ctl got=%b exp=%b", ctl, C_FR); end
    tick();
    total++; if (state !== 4'd2) begin bad++; $display("FAIL fetch_to_decode got=%0d exp=2", state); end
    tick();
    total++; if (state !== 4'd7) begin bad++; $display("FAIL pre_reset_rexec got=%0d exp=7", state); end
    rst_n = 1'b0; #1;
    total++; if (state !== 4'd0) begin bad++; $display("FAIL midrst_state got=%0d exp=0", state); end
    total++; if (ctl !== C_ZERO) begin bad++; $display("FAIL midrst_ctl got=%b exp=%b", ctl, C_ZERO); end
    tick();
    rst_n = 1'b1; #1;
    total++; if (state !== 4'd0) begin bad++; $display("FAIL midrst_hold got=%0d exp=0", state); end
    tick();
    total++; if (state !== 4'd1) begin bad++; $display("FAIL midrst_fetch got=%0d exp=1", state); end
  endtask

  task automatic test_r_type();
    logic [3:0] es [4]; logic [16:0] ec [4];
    es = '{4'd1, 4'd2, 4'd7, 4'd8};
    ec = '{C_FR, C_DEC, C_REX, C_RWB};
    opcode = 6'b000000; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (state !== es[i]) begin bad++; $display("FAIL r_state[%0d] got=%0d exp=%0d", i, state, es[i]); end
      total++; if (ctl !== ec[i]) begin bad++; $display("FAIL r_ctl[%0d] got=%b exp=%b", i, ctl, ec[i]); end
      tick();
    end
    total++; if (state !== 4'd1) begin bad++; $display("FAIL r_cpi got=%0d exp=1", state); end
  endtask

  task automatic test_lw();
    logic [3:0] es [7]; logic [16:0] ec [7]; logic mr [7];
    es = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd5};
    ec = '{C_FR, C_DEC, C_MADDR, C_MRD, C_MRD, C_MRD, C_MWB};
    mr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    opcode = 6'b100011;
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr[i]; #1;
      total++; if (state !== es[i]) begin bad++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, state, es[i]); end
      total++; if (ctl !== ec[i]) begin bad++; $display("FAIL lw_ctl[%0d] got=%b exp=%b", i, ctl, ec[i]); end
      tick();
    end
    total++; if (state !== 4'd1) begin bad++; $display("FAIL lw_cpi got=%0d exp=1", state); end
  endtask

  task automatic test_sw();
    logic [3:0] es [5]; logic [16:0] ec [5]; logic mr [5];
    es = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd6};
    ec = '{C_FR, C_DEC, C_MADDR, C_MWR, C_MWR};
    mr = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    opcode = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr[i]; #1;
      total++; if (state !== es[i]) begin bad++; $display("FAIL sw_state[%0d] got=%0d exp=%0d", i, state, es[i]); end
      total++; if (ctl !== ec[i]) begin bad++; $display("FAIL sw_ctl[%0d] got=%b exp=%b", i, ctl, ec[i]); end
      tick();
    end
    total++; if (state !== 4'd1) begin bad++; $display("FAIL sw_cpi got=%0d exp=1", state); end
  endtask

  task automatic test_branch();
    logic [5:0] op [4]; logic zv [4]; logic [16:0] eb [4];
    op = '{6'b000100, 6'b000101, 6'b000101, 6'b000100};
    zv = '{1'b1, 1'b1, 1'b0, 1'b0};
    eb = '{C_BR1, C_BR0, C_BR1, C_BR0};
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      opcode = op[k]; zero = zv[k];
      tick();
      total++; if (state !== 4'd2) begin bad++; $display("FAIL br_dec[%0d] got=%0d exp=2", k, state); end
      tick();
      total++; if (state !== 4'd9) begin bad++; $display("FAIL br_state[%0d] got=%0d exp=9", k, state); end
      total++; if (ctl !== eb[k]) begin bad++; $display("FAIL br_ctl[%0d] got=%b exp=%b", k, ctl, eb[k]); end
      tick();
      total++; if (state !== 4'd1) begin bad++; $display("FAIL br_cpi[%0d] got=%0d exp=1", k, state); end
    end
    zero = 1'b0;
  endtask

  task automatic test_jump();
    opcode = 6'b000010; mem_ready = 1'b1;
    tick(); tick();
    total++; if (state !== 4'd10) begin bad++; $display("FAIL j_state got=%0d exp=10", state); end
    total++; if (ctl !== C_JMP) begin bad++; $display("FAIL j_ctl got=%b exp=%b", ctl, C_JMP); end
    tick();
    total++; if (state !== 4'd1) begin bad++; $display("FAIL j_cpi got=%0d exp=1", state); end
  endtask

  task automatic test_itype();
    logic [5:0] op [4]; logic [16:0] ee [4]; logic [2:0] ei [4];
    op = '{6'b001101, 6'b001010, 6'b001100, 6'b001000};
    ee = '{C_IEX1, C_IEX0, C_IEX1, C_IEX0};
    ei = '{3'b101, 3'b010, 3'b100, 3'b000};
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      opcode = op[k];
      tick(); tick();
      total++; if (state !== 4'd11) begin bad++; $display("FAIL i_state[%0d] got=%0d exp=11", k, state); end
      total++; if (ctl !== ee[k]) begin bad++; $display("FAIL i_ctl[%0d] got=%b exp=%b", k, ctl, ee[k]); end
      total++; if (i_op !== ei[k]) begin bad++; $display("FAIL i_iop[%0d] got=%b exp=%b", k, i_op, ei[k]); end
      opcode = 6'b111000;
      tick();
      total++; if (ctl !== C_IWB) begin bad++; $display("FAIL i_wb[%0d] got=%b exp=%b", k, ctl, C_IWB); end
      tick();
      total++; if (state !== 4'd1) begin bad++; $display("FAIL i_cpi[%0d] got=%0d exp=1", k, state); end
      total++; if (i_op !== ei[k]) begin bad++; $display("FAIL i_hold[%0d] got=%b exp=%b", k, i_op, ei[k]); end
    end
  endtask

  task automatic test_illegal();
    opcode = 6'b111111; mem_ready = 1'b1;
    tick();
    total++; if (ctl !== C_ILL) begin bad++; $display("FAIL ill_ctl got=%b exp=%b", ctl, C_ILL); end
    tick();
    mem_ready = 1'b0; #1;
    total++; if (state !== 4'd1) begin bad++; $display("FAIL ill_next got=%0d exp=1", state); end
    total++; if (ctl !== C_FW) begin bad++; $display("FAIL ill_pulse got=%b exp=%b", ctl, C_FW); end
  endtask

  task automatic test_async_reset_iop();
    opcode = 6'b001101; mem_ready = 1'b1;
    tick(); tick();
    total++; if (i_op !== 3'b101) begin bad++; $display("FAIL ar_pre got=%b exp=101", i_op); end
    rst_n = 1'b0; #1;
    total++; if (i_op !== 3'b000) begin bad++; $display("FAIL ar_iop got=%b exp=000", i_op); end
    total++; if (ctl !== C_ZERO) begin bad++; $display("FAIL ar_ctl got=%b exp=%b", ctl, C_ZERO); end
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (state !== 4'd1) begin bad++; $display("FAIL ar_fetch got=%0d exp=1", state); end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_lw();
    test_sw();
    test_branch();
    test_jump();
    test_itype();
    test_illegal();
    test_async_reset_iop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
